// File: rtl/data_mem_slave.sv
// rtl/data_mem_slave.sv - single-port 32-bit data memory slave with valid/ready request and response channels
module data_mem_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic                  do_access;
  logic                  a_we;
  logic [31:0]           a_addr;
  logic [1:0]            a_size;
  logic                  a_sign;
  logic [31:0]           a_wdata;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic                  a_err;
  logic [31:0]           cur_word;
  logic [4:0]            byte_sh;
  logic [4:0]            half_sh;
  logic [31:0]           byte_lane;
  logic [31:0]           half_lane;
  logic [31:0]           load_data;
  logic [31:0]           st_mask;
  logic [31:0]           st_data;
  logic [31:0]           merged_word;
  logic                  mem_we;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign accept = req_valid && req_ready;

  // Operand select: with zero latency the access happens on the accept edge, so use the live inputs in IDLE
  always_comb begin
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_size  = req_size;
      a_sign  = req_sign;
      a_wdata = req_wdata;
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_size  = size_q;
      a_sign  = sign_q;
      a_wdata = wdata_q;
    end
  end

  // Address decode, error detection, load lane extraction and store lane merge
  always_comb begin
    a_idx   = a_addr[DEPTH_LOG2+1:2];
    a_err   = (a_size == 2'b11)
            || (a_size == SZ_HALF && a_addr[0])
            || (a_size == SZ_WORD && a_addr[1:0] != 2'b00)
            || (|a_addr[31:DEPTH_LOG2+2]);
    cur_word  = mem_q[a_idx];
    byte_sh   = {a_addr[1:0], 3'b000};
    half_sh   = {a_addr[1], 4'b0000};
    byte_lane = cur_word >> byte_sh;
    half_lane = cur_word >> half_sh;

    load_data = cur_word;
    st_mask   = 32'hFFFF_FFFF;
    st_data   = a_wdata;
    case (a_size)
      SZ_BYTE: begin
        load_data = {{24{a_sign & byte_lane[7]}}, byte_lane[7:0]};
        st_mask   = 32'h0000_00FF << byte_sh;
        st_data   = {24'd0, a_wdata[7:0]} << byte_sh;
      end
      SZ_HALF: begin
        load_data = {{16{a_sign & half_lane[15]}}, half_lane[15:0]};
        st_mask   = 32'h0000_FFFF << half_sh;
        st_data   = {16'd0, a_wdata[15:0]} << half_sh;
      end
      default: begin
        load_data = cur_word;
        st_mask   = 32'hFFFF_FFFF;
        st_data   = a_wdata;
      end
    endcase
    merged_word = (cur_word & ~st_mask) | (st_data & st_mask);
  end

  assign do_access = ((state_q == S_IDLE) && accept && (LATENCY == 0))
                  || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // Next-state logic for the IDLE/WAIT/RESP handshake and response registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          sign_d  = req_sign;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      resp_err_d   = a_err;
      resp_rdata_d = (a_err || a_we) ? 32'd0 : load_data;
      mem_we       = a_we && !a_err;
    end
  end

  // Control and response registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      sign_q       <= 1'b0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Storage array: cleared on reset, reset wins over a pending store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem_q[a_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_data_mem_slave.sv
// tb/tb_data_mem_slave.sv - directed self-checking bench for data_mem_slave
module tb_data_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_we1, req_sign1;
  logic [31:0] req_addr1, req_wdata1;
  logic [1:0]  req_size1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [31:0] resp_rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_slave #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_slave #(.DEPTH_LOG2(4), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_size(req_size1), .req_sign(req_sign1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  // One full transaction on the LATENCY=2 instance; lat = negedges from accept until resp_valid (0 = timeout)
  task automatic request(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_sign = sign; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_size = 2'b11;
    req_sign = ~sign; req_wdata = ~wdata;
    lat = 0; rdata = 32'hX; err = 1'bX;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat != 0) begin
      rdata = resp_rdata;
      err   = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    @(posedge clk);
    #1 reset = 1'b0;
    request(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_mem_0x10 got %h want 0", rd); end
    request(1'b0, 32'h0000_0FFC, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_bad++; $display("FAIL reset_mem_top got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    request(1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL store_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_bad++; $display("FAIL store_resp got %h/%b want 0/0", rd, er); end
    request(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL load_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_bad++; $display("FAIL load_word got %h/%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addr_v [5] = '{32'h13, 32'h10, 32'h12, 32'h11, 32'h11};
    logic [1:0]  size_v [5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    logic        sign_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_v  [5] = '{32'h0000_007F, 32'h7FAD_BEEF, 32'h0000_7FAD, 32'hFFFF_FFBE, 32'h0000_00BE};
    request(1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'hAAAA_AA7F, rd, er, lat);
    n_cmp++; if (er !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL store_byte_resp got %h/%b want 0/0", rd, er); end
    for (int i = 0; i < 5; i++) begin
      request(1'b0, addr_v[i], size_v[i], sign_v[i], 32'd0, rd, er, lat);
      n_cmp++;
      if (rd !== exp_v[i] || er !== 1'b0) begin
        n_bad++; $display("FAIL lane_load_%0d got %h/%b want %h/0", i, rd, er, exp_v[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        we_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] addr_v [5] = '{32'h02, 32'h01, 32'h10, 32'h0000_1010, 32'h11};
    logic [1:0]  size_v [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      request(we_v[i], addr_v[i], size_v[i], 1'b0, 32'hCAFE_F00D, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'd0) begin
        n_bad++; $display("FAIL err_case_%0d got %h/%b want 0/1", i, rd, er);
      end
    end
    request(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'h7FAD_BEEF) begin n_bad++; $display("FAIL err_mem_unchanged got %h want 7fadbeef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_sign = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", lat); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10; req_wdata = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h7FAD_BEEF || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d got v=%b d=%h rdy=%b want 1/7fadbeef/0", c, resp_valid, resp_rdata, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    request(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'h7FAD_BEEF) begin n_bad++; $display("FAIL bp_ignored_store got %h want 7fadbeef", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL wait_reset got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    request(1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL wait_reset_mem got %h want 0", rd); end
    request(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_cleared_mem got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic        we_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr_v [4] = '{32'h4, 32'h4, 32'h6, 32'h6};
    logic [1:0]  size_v [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
    logic [31:0] wd_v   [4] = '{32'hA5A5_A5A5, 32'h0, 32'h0000_0080, 32'h0};
    logic [31:0] exp_v  [4] = '{32'h0, 32'hA5A5_A5A5, 32'h0, 32'hFFFF_FF80};
    @(negedge clk);
    resp_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid1 = 1'b1; req_we1 = we_v[i]; req_addr1 = addr_v[i];
      req_size1 = size_v[i]; req_sign1 = 1'b1; req_wdata1 = wd_v[i];
      n_cmp++; if (req_ready1 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d got %b want 1", i, req_ready1); end
      @(negedge clk);
      n_cmp++;
      if (resp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || resp_rdata1 !== exp_v[i] || resp_err1 !== 1'b0) begin
        n_bad++; $display("FAIL b2b_resp_%0d got v=%b rdy=%b d=%h e=%b want 1/0/%h/0", i, resp_valid1, req_ready1, resp_rdata1, resp_err1, exp_v[i]);
      end
      @(negedge clk);
      n_cmp++; if (resp_valid1 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_%0d got %b want 0", i, resp_valid1); end
    end
    req_valid1 = 1'b0;
    resp_ready1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_sign = 1'b0; req_wdata = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_size1 = '0; req_sign1 = 1'b0; req_wdata1 = '0;
    resp_ready1 = 1'b0;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_slave.md
DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets storage depth to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 2, sets wait cycles between request accept and access (legal 0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  slave can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_sign  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  initiator consumes response.
REQ-015 resp_rdata  output  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-016 resp_err  output  1  request was misaligned, illegal size, or out of range.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: accept when req_valid && req_ready on a rising edge; latch we, addr, size, sign, wdata; input changes after accept are ignored.
REQ-019 On accept: LATENCY>0 -> WAIT with counter = LATENCY-1; LATENCY=0 -> access performed on the accept edge, go to RESP.
REQ-020 In WAIT: counter decrements each cycle; on the edge where counter==0, perform access, load resp_rdata/resp_err, go to RESP.
REQ-021 Latency: accept on edge k -> resp_valid high in the cycle following edge k+LATENCY (LATENCY+1 cycles).
REQ-022 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_valid && resp_ready on an edge, then IDLE; back-pressure holds indefinitely.
REQ-023 No request accepted on the RESP->IDLE edge; minimum request spacing is LATENCY+2 cycles.
REQ-024 Word index = addr[DEPTH_LOG2+1:2]; out of range when addr[31:DEPTH_LOG2+2] != 0.
REQ-025 Error when size==11, halfword with addr[0]=1, word with addr[1:0]!=0, or out of range; error -> no write, resp_rdata=0, resp_err=1.
REQ-026 Little-endian lanes: byte at addr[1:0]*8; half at addr[1]*16; stores modify only the addressed lanes, others retain value.
REQ-027 Loads: select addressed byte/half, extend per latched sign; word loads unmodified.
REQ-028 Stores: resp_rdata=0, resp_err=0 when legal; the write is visible to any later load.
REQ-029 resp_valid, resp_err, resp_rdata SHALL be registered outputs; req_ready is decoded from the state register.

Reset
REQ-030 Reset sets state IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1 in the following cycle, and all storage words 0.
REQ-031 Reset in WAIT or RESP aborts the transaction; a store not yet committed SHALL NOT be written.
REQ-032 Reset takes priority over accept, access, and response handshake on the same edge.

Verification
REQ-033 Store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid high 3 cycles after each accept (LATENCY=2).
REQ-034 After REQ-033: store byte 0x7F @0x13, load byte signed @0x13 -> 0x0000007F; load word @0x10 -> 0x7FADBEEF; load half signed @0x12 -> 0x00007FAD; load byte signed @0x11 -> 0xFFFFFFBE; load byte unsigned @0x11 -> 0x000000BE.
REQ-035 Load word @0x02, load half @0x01, req_size=11, store @0x00001000 (DEPTH_LOG2=10) -> resp_err 1, resp_rdata 0, memory unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready 0, new req_valid ignored; resp_ready=1 -> IDLE next cycle.
REQ-037 Accept store 0x12345678 @0x20, assert reset in WAIT -> resp_valid 0 after reset; load word @0x20 -> 0x00000000.
REQ-038 LATENCY=0 build: accept on edge k -> resp_valid high after edge k; back-to-back requests accepted every 2 cycles with resp_ready held 1.
